// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NREG     = 32;

  // Architectural zero register: never written, never tracked as busy.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = source A, bit 1 = source B.
module rr_arb2
  import regfile_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t last_grant;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (FIXED_PRIO || (last_grant == SRC_B)) gnt = 2'b01;
          else                                     gnt = 2'b10;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the winner of the last transfer; reset favours A next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_B;
    end else if (gnt[0]) begin
      last_grant <= SRC_A;
    end else if (gnt[1]) begin
      last_grant <= SRC_B;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (A) and load (B) writeback,
// and tracks pending destination registers for decode hazard checks.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W,
  parameter int unsigned NREG       = regfile_pkg::NREG,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic [NREG-1:0]   busy_mask,
  output logic              issue_hazard
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);

  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wr;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   busy_next;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign xfer    = |gnt;

  // Steer the granted source's payload; accepted r0 writes are dropped.
  always_comb begin
    sel_rd   = a_rd;
    sel_data = a_data;
    if (gnt[1]) begin
      sel_rd   = b_rd;
      sel_data = b_data;
    end
    sel_wr = xfer && (sel_rd != RD_ZERO);
  end

  // Scoreboard update: retire on acceptance, newer issue overrides retire.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (sel_wr) begin
      clr_vec[sel_rd] = 1'b1;
    end
    if (issue_valid && (issue_rd != RD_ZERO)) begin
      set_vec[issue_rd] = 1'b1;
    end
    busy_next    = (busy_mask & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
  end

  // Hazard is judged on the registered mask only.
  assign issue_hazard = issue_valid && busy_mask[issue_rd];

  // Registered write port; address/data hold when no write occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write <= 1'b0;
      rf_rd    <= '0;
      rf_data  <= '0;
    end else begin
      rf_write <= sel_wr;
      if (sel_wr) begin
        rf_rd   <= sel_rd;
        rf_data <= sel_data;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, issue_rd;
  logic [31:0] a_data, b_data;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] busy_mask;
  logic        issue_hazard;

  int total;
  int bad;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdat;
    logic        iv;
    logic [4:0]  ird;
    logic        e_ar;
    logic        e_br;
    logic        e_hz;
    logic        e_w;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rf_write     (rf_write),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .busy_mask    (busy_mask),
    .issue_hazard (issue_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                       input logic iv, input logic [4:0] ird);
    a_valid = av; a_rd = ard; a_data = adat;
    b_valid = bv; b_rd = brd; b_data = bdat;
    issue_valid = iv; issue_rd = ird;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           av ard  adat          bv brd  bdat         iv ird   ar br hz  w  rd   dat           busy
    vec[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0,        32'h0};
    vec[1]  = '{1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0,     0, 5'd0, 1, 0, 0, 1, 5'd5, 32'h12345678, 32'h0};
    vec[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd0, 0, 0, 0, 0, 5'd5, 32'h12345678, 32'h0};
    vec[3]  = '{1, 5'd3, 32'hA,        1, 5'd4, 32'hB,     0, 5'd0, 0, 1, 0, 1, 5'd4, 32'hB,        32'h0};
    vec[4]  = '{1, 5'd3, 32'hA,        1, 5'd8, 32'hBB,    0, 5'd0, 1, 0, 0, 1, 5'd3, 32'hA,        32'h0};
    vec[5]  = '{1, 5'd9, 32'hAA,       1, 5'd8, 32'hBB,    0, 5'd0, 0, 1, 0, 1, 5'd8, 32'hBB,       32'h0};
    vec[6]  = '{1, 5'd9, 32'hAA,       0, 5'd0, 32'h0,     0, 5'd0, 1, 0, 0, 1, 5'd9, 32'hAA,       32'h0};
    vec[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 5'd7, 0, 0, 0, 0, 5'd9, 32'hAA,       32'h80};
    vec[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 5'd7, 0, 0, 1, 0, 5'd9, 32'hAA,       32'h80};
    vec[9]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h77,    0, 5'd0, 0, 1, 0, 1, 5'd7, 32'h77,       32'h0};
    vec[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 5'd7, 0, 0, 0, 0, 5'd7, 32'h77,       32'h80};
    vec[11] = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h70,    1, 5'd7, 0, 1, 1, 1, 5'd7, 32'h70,       32'h80};
    vec[12] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,     1, 5'd0, 1, 0, 0, 0, 5'd7, 32'h70,       32'h80};
    vec[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 5'd4, 0, 0, 0, 0, 5'd7, 32'h70,       32'h90};
    vec[14] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 5'd5, 0, 0, 0, 0, 5'd7, 32'h70,       32'hB0};
    vec[15] = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h1,     0, 5'd0, 0, 1, 0, 1, 5'd7, 32'h1,        32'h30};

    // Reset held for three cycles with idle sources.
    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_write", 32'(rf_write), 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_ready", {30'h0, b_ready, a_ready}, 32'h0);
    rst = 1'b1;

    // Table: inputs at posedge+1, combinational checks at negedge, registered at next posedge+1.
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].av, vec[i].ard, vec[i].adat, vec[i].bv, vec[i].brd, vec[i].bdat,
            vec[i].iv, vec[i].ird);
      #4;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vec[i].e_ar));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vec[i].e_br));
      chk($sformatf("v%0d hazard", i), 32'(issue_hazard), 32'(vec[i].e_hz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_write", i), 32'(rf_write), 32'(vec[i].e_w));
      chk($sformatf("v%0d rf_rd", i), 32'(rf_rd), 32'(vec[i].e_rd));
      chk($sformatf("v%0d rf_data", i), rf_data, vec[i].e_dat);
      chk($sformatf("v%0d busy", i), busy_mask, vec[i].e_busy);
    end

    // Mid-cycle async reset with both sources valid and writes in flight.
    drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 0, 5'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst rf_write", 32'(rf_write), 32'h0);
    chk("mid_rst busy", busy_mask, 32'h0);
    chk("mid_rst ready", {30'h0, b_ready, a_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst held busy", busy_mask, 32'h0);
    rst = 1'b1;
    #4;
    chk("post_rst grant", {30'h0, b_ready, a_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst wr1 en", 32'(rf_write), 32'h1);
    chk("post_rst wr1", {rf_rd, rf_data[26:0]}, {5'd3, 27'hA});
    #4;
    chk("post_rst grant2", {30'h0, b_ready, a_ready}, 32'h2);
    @(posedge clk);
    #1;
    chk("post_rst wr2", {rf_rd, rf_data[26:0]}, {5'd4, 27'hB});
    #4;
    chk("post_rst grant3", {30'h0, b_ready, a_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst wr3", {rf_rd, rf_data[26:0]}, {5'd3, 27'hA});
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
    @(posedge clk);
    #1;
    chk("final idle write", 32'(rf_write), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources: A (ALU result) and B (load/memory result).
- Uses a round-robin valid/ready handshake per source and drives a registered write port (write, rd, input_data) into the regfile.
- Keeps a 32-bit pending-write scoreboard. Decode sets bits at issue; the arbiter clears them at writeback. Decode uses the mask to stall on hazards.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width.
- NREG, 32, number of registers (2**ADDR_W).
- FIXED_PRIO, 0, 0 = round-robin; 1 = source A always wins.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-low reset.
- a_valid, input, 1, source A has a write pending.
- a_ready, output, 1, source A accepted this cycle.
- a_rd, input, ADDR_W, source A destination register.
- a_data, input, DATA_W, source A write data.
- b_valid, input, 1, source B has a write pending.
- b_ready, output, 1, source B accepted this cycle.
- b_rd, input, ADDR_W, source B destination register.
- b_data, input, DATA_W, source B write data.
- issue_valid, input, 1, decode issues an instruction that will write issue_rd.
- issue_rd, input, ADDR_W, destination of the issued instruction.
- rf_write, output, 1, registered write enable to the regfile.
- rf_rd, output, ADDR_W, registered write address.
- rf_data, output, DATA_W, registered write data.
- busy_mask, output, NREG, bit r = write to r pending.
- issue_hazard, output, 1, combinational: issue_valid and busy_mask[issue_rd].

Behaviour:
- Reset (rst low, asynchronous): rf_write=0, rf_rd=0, rf_data=0, busy_mask=0, last_grant=B (so A wins the first contention). a_ready=b_ready=0 while rst is low.
- Reset mid-operation: in-flight grants and pending bits are discarded. The first accept is possible on the first edge after rst deasserts.
- Grant, combinational:
  - Only A valid -> A.
  - Only B valid -> B.
  - Both valid -> the source not equal to last_grant (round-robin). With FIXED_PRIO=1, A always wins.
  - Neither valid -> no grant.
- a_ready/b_ready are asserted only for the granted source, at most one per cycle. A transfer occurs on valid&&ready at the rising edge.
- Sources hold valid/rd/data stable until accepted. The arbiter never drops an accepted request. An unaccepted request waits with no timeout.
- last_grant updates only on a transfer.
- Latency: 1 cycle. On a transfer at edge N, rf_write=1 with that rd/data during cycle N+1. With no transfer, rf_write=0 next cycle and rf_rd/rf_data hold their previous values.
- Back-to-back: one write per cycle. Both sources continuously valid -> alternating A,B,A,B writes.
- rd=0: accepted (ready asserted, last_grant updated) but rf_write stays 0. r0 is never written and busy_mask[0] is always 0.
- Scoreboard:
  - Set: issue_valid with issue_rd!=0 sets busy_mask[issue_rd] at the edge.
  - Clear: a transfer with rd!=0 clears busy_mask[rd] at the same edge as acceptance.
  - Simultaneous set and clear of the same r: set wins (a newer write is in flight).
- Both sources may target the same rd in consecutive grants. Writes reach the regfile in grant order.
- issue_hazard uses the registered busy_mask only; a same-cycle clear does not suppress it.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NREG constants.
  - wb_src_t enum {SRC_A=0, SRC_B=1}.
  - Register index constant REG_ZERO=0.
- One sub-module, rr_arb2: 2-way round-robin arbiter with FIXED_PRIO, inputs req[1:0], output gnt[1:0], holding the last_grant flop.
- The write-port register and scoreboard stay in regfile_wb_arbiter.

Test Plan:
- Reset, then idle: hold rst=0 for 3 cycles, release, with no valids -> rf_write=0, busy_mask=0, a_ready=b_ready=0 throughout.
- Single source: a_valid=1, a_rd=5, a_data=0x1234_5678 for one cycle -> a_ready=1 that cycle; next cycle rf_write=1, rf_rd=5, rf_data=0x12345678; then rf_write=0.
- Contention: A (rd=3, data=0xA) and B (rd=4, data=0xB) both held valid from reset -> grants A then B. rf writes: (3,0xA) then (4,0xB). Repeat with new data -> strictly alternating A,B,A,B.
- Scoreboard:
  - issue_valid, issue_rd=7 -> busy_mask=0x80.
  - Next cycle issue_rd=7 again -> issue_hazard=1.
  - B writes rd=7 -> bit clears on the acceptance edge.
  - Issue 7 in the same cycle as B's acceptance of rd=7 -> bit remains 1.
- r0 writes: a_valid, a_rd=0, a_data=0xFFFF_FFFF -> a_ready=1, rf_write stays 0. issue_rd=0 -> busy_mask stays 0.
- Reset mid-operation:
  - Setup: busy_mask=0x0000_0030, A and B both valid.
  - Assert rst asynchronously mid-cycle -> immediately rf_write=0, busy_mask=0, readies=0.
  - After release with both still valid -> A granted first.
